// File: rtl/johnson_counter_param.sv
// Parametrised Johnson counter with enable, direction, parallel load, phase index and wrap pulse.
// Define JOHNSON_SELF_CORRECT_EN to reject illegal loads and scrub illegal states.
module johnson_counter_param #(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    localparam int unsigned    W_U        = WIDTH;
    localparam int unsigned    SEQ_LEN    = 2 * W_U;
    localparam logic [PW-1:0]  LAST_PHASE = PW'(SEQ_LEN - 1);

    typedef struct packed {
        logic          legal;
        logic [PW-1:0] idx;
    } dec_t;

    // Phase k <= WIDTH: k LSBs set; phase k > WIDTH: low (k-WIDTH) bits clear, rest set.
    function automatic dec_t decode(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] code;
        dec_t             res;
        res = '0;
        for (int unsigned k = 0; k < SEQ_LEN; k++) begin
            if (k <= W_U) begin
                code = (WIDTH'(1) << k) - WIDTH'(1);
            end else begin
                code = ~((WIDTH'(1) << (k - W_U)) - WIDTH'(1));
            end
            if (v == code) begin
                res.legal = 1'b1;
                res.idx   = PW'(k);
            end
        end
        return res;
    endfunction

    logic [WIDTH-1:0] q_q, q_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    dec_t             q_dec, lv_dec;

    always_comb begin
        q_d     = q_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        q_dec   = decode(q_q);
        lv_dec  = decode(load_val);

        if (load) begin
            if (lv_dec.legal) begin
                q_d     = load_val;
                phase_d = lv_dec.idx;
            end else begin
`ifdef JOHNSON_SELF_CORRECT_EN
                q_d     = '0;
                phase_d = '0;
                err_d   = 1'b1;
`else
                q_d     = load_val;
                phase_d = '0;
`endif
            end
        end
`ifdef JOHNSON_SELF_CORRECT_EN
        else if (!q_dec.legal) begin
            q_d     = '0;
            phase_d = '0;
            err_d   = 1'b1;
        end
`endif
        else if (en) begin
            if (dir) begin
                q_d = {~q_q[0], q_q[WIDTH-1:1]};
            end else begin
                q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            end
            // Stepping from an illegal code stays illegal, so phase stays 0 and no wrap.
            if (q_dec.legal) begin
                if (dir) begin
                    phase_d = (q_dec.idx == '0) ? LAST_PHASE : q_dec.idx - 1'b1;
                    wrap_d  = (q_dec.idx == '0);
                end else begin
                    phase_d = (q_dec.idx == LAST_PHASE) ? '0 : q_dec.idx + 1'b1;
                    wrap_d  = (q_dec.idx == LAST_PHASE);
                end
            end else begin
                phase_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= '0;
            phase_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign q     = q_q;
    assign phase = phase_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_johnson_counter_param.sv
// Self-checking bench for johnson_counter_param: directed plan plus randomized run against a phase-based model.
module tb_johnson_counter_param;

    localparam int W  = 4;
    localparam int PW = $clog2(2*W);
    localparam int N  = 2*W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          dir = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [W-1:0]  q;
    logic [PW-1:0] phase;
    logic          wrap;
    logic          err;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    johnson_counter_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .q(q), .phase(phase), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int code_of(input int k);
        if (k <= W) return (1 << k) - 1;
        return ((1 << W) - 1) ^ ((1 << (k - W)) - 1);
    endfunction

    function automatic int idx_of(input int v);
        for (int k = 0; k < N; k++) if (code_of(k) == v) return k;
        return -1;
    endfunction

    // Model state: q as an integer, phase as an integer 0..N-1
    int m_q = 0, m_ph = 0, m_wrap = 0, m_err = 0;

    always @(posedge clk) begin
        int k;
        int mask;
        mask = (1 << W) - 1;
        m_wrap = 0;
        m_err  = 0;
        if (rst) begin
            m_q = 0; m_ph = 0;
        end else if (load) begin
            k = idx_of(int'(load_val));
            if (k >= 0) begin
                m_q = int'(load_val); m_ph = k;
            end else begin
`ifdef JOHNSON_SELF_CORRECT_EN
                m_q = 0; m_ph = 0; m_err = 1;
`else
                m_q = int'(load_val); m_ph = 0;
`endif
            end
        end else if (en) begin
            if (idx_of(m_q) >= 0) begin
                if (!dir) begin
                    m_wrap = (m_ph == N-1);
                    m_ph = (m_ph + 1) % N;
                end else begin
                    m_wrap = (m_ph == 0);
                    m_ph = (m_ph + N - 1) % N;
                end
                m_q = code_of(m_ph);
            end else begin
                if (!dir) m_q = ((m_q << 1) | (((~m_q) >> (W-1)) & 1)) & mask;
                else      m_q = ((m_q >> 1) | (((~m_q) & 1) << (W-1))) & mask;
                m_ph = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("model_q",     32'(q),     32'(m_q));
            chk("model_phase", 32'(phase), 32'(m_ph));
            chk("model_wrap",  32'(wrap),  32'(m_wrap));
            chk("model_err",   32'(err),   32'(m_err));
        end
    end

    task automatic cyc(input logic r, input logic l, input logic [W-1:0] lv,
                       input logic e, input logic d);
        @(negedge clk);
        rst = r; load = l; load_val = lv; en = e; dir = d;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] up_q [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                               4'b1100, 4'b1000, 4'b0000, 4'b0001};
    int           up_ph [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    initial begin
        cyc(1, 0, '0, 0, 0);
        checking = 1'b1;
        cyc(1, 0, '0, 0, 0);
        chk("reset_q", 32'(q), 0);
        chk("reset_phase", 32'(phase), 0);
        chk("reset_wrap_err", 32'({wrap, err}), 0);

        // Count up for 9 edges
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, '0, 1, 0);
            chk("up_q", 32'(q), 32'(up_q[i]));
            chk("up_phase", 32'(phase), 32'(up_ph[i]));
            chk("up_wrap", 32'(wrap), (i == 7) ? 1 : 0);
        end

        // Count down from reset
        cyc(1, 0, '0, 0, 0);
        cyc(0, 0, '0, 1, 1);
        chk("dn_q0", 32'(q), 32'h8); chk("dn_ph0", 32'(phase), 7); chk("dn_wrap0", 32'(wrap), 1);
        cyc(0, 0, '0, 1, 1);
        chk("dn_q1", 32'(q), 32'hC); chk("dn_ph1", 32'(phase), 6); chk("dn_wrap1", 32'(wrap), 0);
        cyc(0, 0, '0, 1, 1);
        chk("dn_q2", 32'(q), 32'hE); chk("dn_ph2", 32'(phase), 5);

        // Load has priority over enable
        cyc(1, 0, '0, 0, 0);
        cyc(0, 0, '0, 1, 0);
        cyc(0, 0, '0, 1, 0);
        chk("pre_load_q", 32'(q), 32'h3);
        cyc(0, 1, 4'b1110, 1, 0);
        chk("load_q", 32'(q), 32'hE); chk("load_ph", 32'(phase), 5); chk("load_wrap", 32'(wrap), 0);
        cyc(0, 0, '0, 1, 0);
        chk("after_load_q", 32'(q), 32'hC); chk("after_load_ph", 32'(phase), 6);

        // Illegal load
        cyc(0, 1, 4'b0101, 1, 0);
`ifdef JOHNSON_SELF_CORRECT_EN
        chk("ill_q", 32'(q), 0); chk("ill_ph", 32'(phase), 0); chk("ill_err", 32'(err), 1);
        cyc(0, 0, '0, 0, 0);
        chk("ill_err_clear", 32'(err), 0);
`else
        chk("ill_q", 32'(q), 32'h5); chk("ill_ph", 32'(phase), 0); chk("ill_err", 32'(err), 0);
        cyc(0, 0, '0, 1, 0);
        chk("ill_step_q", 32'(q), 32'hB); chk("ill_step_ph", 32'(phase), 0);
`endif

        // Hold then direction flip
        cyc(1, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, '0, 0, i[0]);
            chk("hold_q", 32'(q), 32'h7); chk("hold_wrap", 32'(wrap), 0);
        end
        cyc(0, 0, '0, 1, 0); chk("flip_q0", 32'(q), 32'hF); chk("flip_ph0", 32'(phase), 4);
        cyc(0, 0, '0, 1, 1); chk("flip_q1", 32'(q), 32'h7); chk("flip_ph1", 32'(phase), 3);
        cyc(0, 0, '0, 1, 0); chk("flip_q2", 32'(q), 32'hF);

        // Reset together with load while counting
        cyc(0, 0, '0, 1, 0);
        cyc(1, 1, 4'b0101, 1, 1);
        chk("rstld_q", 32'(q), 0); chk("rstld_ph", 32'(phase), 0);
        chk("rstld_wrap_err", 32'({wrap, err}), 0);
        cyc(0, 0, '0, 1, 0);
        chk("restart_q", 32'(q), 32'h1); chk("restart_ph", 32'(phase), 1);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] lv;
            lv = ($urandom_range(1) == 1) ? W'(code_of(int'($urandom_range(N-1))))
                                          : W'($urandom);
            cyc($urandom_range(63) == 0, $urandom_range(7) == 0, lv,
                $urandom_range(3) != 0, 1'($urandom));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/johnson_counter_param.md
# johnson_counter_param

Parametrised Johnson (twisted-ring) counter for the sequential-circuit library. It replaces the fixed 4-bit free-running version with these additions:
- configurable width;
- count enable and up/down direction;
- synchronous parallel load;
- registered phase index and wrap pulse;
- optional illegal-state correction.

It is intended as a glitch-free phase/sequence generator for timing strobes and multi-phase enables.

## Interface
- `WIDTH`, default 4: ring width in bits. Legal range ≥ 2. The sequence length is 2·WIDTH.
- `PW`, default `$clog2(2*WIDTH)`: width of the phase index. Derived; do not override.
- `clk` input, 1 bit: the only clock. All state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset. It has priority over every other input.
- `en` input, 1 bit: count enable. When low, the counter holds.
- `dir` input, 1 bit: 0 = count up (forward sequence), 1 = count down (reverse sequence).
- `load` input, 1 bit: synchronous parallel load. It has priority over `en`.
- `load_val` input, WIDTH bits: value to load.
- `q` output, WIDTH bits: counter state (registered).
- `phase` output, PW bits: index 0..2·WIDTH−1 of `q` within the sequence (registered, aligned with `q`).
- `wrap` output, 1 bit: one-cycle pulse marking a sequence wrap (registered).
- `err` output, 1 bit: one-cycle pulse flagging an illegal load (registered).

## Operation
- **Legal codes.** There are 2·WIDTH of them.
  - Phase k for 0 ≤ k ≤ WIDTH: the k LSBs are 1 and the rest are 0.
  - Phase k for WIDTH < k < 2·WIDTH: the (2·WIDTH−k) MSBs are 1 and the rest are 0.
  - Every other pattern is illegal.
- **Up step (`dir`=0):** `q` ← {`q`[WIDTH−2:0], ~`q`[WIDTH−1]}; `phase` ← `phase`+1 mod 2·WIDTH.
- **Down step (`dir`=1):** `q` ← {~`q`[0], `q`[WIDTH−1:1]}; `phase` ← `phase`−1 mod 2·WIDTH.
- **Priority per edge:** `rst` > `load` > `en` > hold.
- **Reset:** `q`=0, `phase`=0, `wrap`=0, `err`=0.
- **Load:**
  - `q` ← `load_val`.
  - `phase` ← the decoded index of `load_val`, or 0 if `load_val` is illegal.
  - `wrap` is 0 on the following cycle.
  - `en` and `dir` are ignored on that edge.
- **Wrap:**
  - Up step from phase 2·WIDTH−1 to 0: `wrap`=1 for exactly the next cycle.
  - Down step from phase 0 to 2·WIDTH−1: `wrap`=1 for exactly the next cycle.
  - Otherwise `wrap`=0, including while holding.
- **`dir` changes:** `dir` may change on any cycle. The next step uses the new direction. No dead cycle and no state skip.
- **Hold (`en`=0, `load`=0):** `q` and `phase` are unchanged; `wrap`=0, `err`=0.

## Timing
- All outputs are registered. `q`, `phase`, `wrap` and `err` change only on a rising edge of `clk`.
- Latency: one cycle from input sampling to output.
- `phase` always corresponds to the current `q`. There is no cycle skew between them.
- Reset mid-sequence: the next edge forces the reset values regardless of `load`, `en` or `dir`. Counting resumes from phase 0 on the first edge after `rst` falls.
- `load` and `rst` asserted together: reset wins, `err`=0.
- Back-to-back loads: each load takes effect on its own edge.

## Configuration
- Macro: `JOHNSON_SELF_CORRECT_EN`.
- **Defined:**
  - An illegal `load_val` is not stored. `q` ← 0, `phase` ← 0, and `err`=1 for one cycle.
  - As a safety net, any illegal `q` found at an edge (e.g. after an SEU) is also forced to 0 and raises `err` for one cycle. This check has priority over `en`, but not over `rst` or `load`.
  - `q` is therefore always a legal code.
- **Undefined:**
  - An illegal `load_val` is stored as-is. While `q` is illegal, `phase` reads 0 and `err` is tied 0.
  - Up and down steps apply the shift rules unchanged, so the illegal pattern orbits in its own cycle and never self-recovers.
  - Only `rst` or a legal load restores the normal sequence.

## Test plan
All scenarios use WIDTH=4.
- **Reset then count up:** reset, then `en`=1, `dir`=0 for 9 edges.
  - `q` = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
  - `phase` = 1..7, 0, 1.
  - `wrap`=1 only in the cycle where `q`=0000 after 1000.
- **Down from reset:** `en`=1, `dir`=1 from `q`=0000.
  - `q` = 1000, 1100, 1110; `phase` = 7, 6, 5.
  - `wrap`=1 in the cycle where `q`=1000.
- **Load priority:** at `q`=0011, assert `load`=1 with `load_val`=1110 and `en`=1.
  - Next cycle: `q`=1110, `phase`=5, `wrap`=0.
  - Following up step: `q`=1100, `phase`=6.
- **Illegal load (macro defined):** `load_val`=0101.
  - Next cycle: `q`=0000, `phase`=0, `err`=1; the cycle after, `err`=0.
  - Without the macro: `q`=0101, `phase`=0, `err`=0. Next up step gives `q`=1011.
- **Hold and direction flip:** `en`=0 for 3 cycles at `q`=0111. `q` holds and `wrap`=0. Then `en`=1 with `dir` toggling each cycle: `q` alternates 1111, 0111, 1111.
- **Reset mid-operation:** `rst`=1 together with `load`=1 while counting.
  - Next cycle: all outputs at their reset values.
  - Counting restarts at `q`=0001 on the first edge after `rst` falls.
